// File: rtl/gray_code_counter.sv
// Up/down binary counter emitting Gray-coded words on a valid/ready stream,
// with binary load, optional saturation and a terminal-count sideband.
module gray_code_counter #(
  parameter int unsigned W    = 4,
  parameter bit          WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] g_out,
  output logic         valid,
  input  logic         ready,
  output logic         tc
);

  localparam logic [0:0]   EMPTY    = 1'b0;
  localparam logic [0:0]   FULL     = 1'b1;
  localparam logic [W-1:0] ALL_ONES = '1;
  localparam logic [W-1:0] ZERO     = '0;

  logic [0:0]   state, state_nxt;
  logic [W-1:0] b, b_nxt;
  logic [W-1:0] g_nxt;
  logic         tc_nxt;
  logic [W-1:0] b_step;
  logic         at_term;
  logic         blocked;
  logic         slot_free;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Next-count arithmetic; saturating build refuses to step past the terminal value
  always_comb begin
    b_step    = up ? (b + W'(1)) : (b - W'(1));
    at_term   = up ? (b == ALL_ONES) : (b == ZERO);
    blocked   = !WRAP && at_term;
    slot_free = (state == EMPTY) || ready;
  end

  // Next-state and next-output decode: load, then step, then drain
  always_comb begin
    state_nxt = state;
    b_nxt     = b;
    g_nxt     = g_out;
    tc_nxt    = tc;
    if (load) begin
      state_nxt = FULL;
      b_nxt     = ld_val;
      g_nxt     = to_gray(ld_val);
      tc_nxt    = ((ld_val == ALL_ONES) && up) || ((ld_val == ZERO) && !up);
    end else if (en && slot_free && !blocked) begin
      state_nxt = FULL;
      b_nxt     = b_step;
      g_nxt     = to_gray(b_step);
      tc_nxt    = (up && (b_step == ALL_ONES)) || (!up && (b_step == ZERO));
    end else if ((state == FULL) && ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      b     <= '0;
      g_out <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      b     <= b_nxt;
      g_out <= g_nxt;
      tc    <= tc_nxt;
    end
  end

  assign valid = (state == FULL);

endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench for gray_code_counter: a wrapping instance and a saturating
// instance, each with its own expected-word queue drained by a handshake monitor.
module tb_gray_code_counter;

  logic       clk = 1'b0;
  // wrapping instance
  logic       rst, en, up, load, ready;
  logic [3:0] ld_val, g_out;
  logic       valid, tc;
  // saturating instance
  logic       rst_s, en_s, up_s, load_s, ready_s;
  logic [3:0] ld_s, g_out_s;
  logic       valid_s, tc_s;

  logic [4:0] q_w[$];
  logic [4:0] q_s[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gray_code_counter #(.W(4), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .ld_val(ld_val),
    .g_out(g_out), .valid(valid), .ready(ready), .tc(tc)
  );

  gray_code_counter #(.W(4), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst_s), .en(en_s), .up(up_s), .load(load_s), .ld_val(ld_s),
    .g_out(g_out_s), .valid(valid_s), .ready(ready_s), .tc(tc_s)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each handshake seen away from the edge consumes one expected {g_out, tc}
  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) begin
      if (q_w.size() == 0) begin
        chk("wrap_unexpected_word", {3'b0, g_out, tc}, 8'hFF);
      end else begin
        chk("wrap_word", {3'b0, g_out, tc}, {3'b0, q_w.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (valid_s === 1'b1 && ready_s === 1'b1) begin
      if (q_s.size() == 0) begin
        chk("sat_unexpected_word", {3'b0, g_out_s, tc_s}, 8'hFF);
      end else begin
        chk("sat_word", {3'b0, g_out_s, tc_s}, {3'b0, q_s.pop_front()});
      end
    end
  end

  // Hand-computed counting sequence from reset: {gray, tc}
  logic [4:0] t1_exp [16] = '{
    5'b0001_0, 5'b0011_0, 5'b0010_0, 5'b0110_0,
    5'b0111_0, 5'b0101_0, 5'b0100_0, 5'b1100_0,
    5'b1101_0, 5'b1111_0, 5'b1110_0, 5'b1010_0,
    5'b1011_0, 5'b1001_0, 5'b1000_1, 5'b0000_0
  };

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; ready = 1'b0; ld_val = 4'd0;
    rst_s = 1'b1; en_s = 1'b0; up_s = 1'b1; load_s = 1'b0; ready_s = 1'b0; ld_s = 4'd0;
    step(2);
    chk("reset_g_out", {4'b0, g_out}, 8'h00);
    chk("reset_valid", {7'b0, valid}, 8'h00);
    chk("reset_tc",    {7'b0, tc},    8'h00);

    // T1: free-running up count with READY held
    for (int i = 0; i < 16; i++) q_w.push_back(t1_exp[i]);
    rst = 1'b0; en = 1'b1; up = 1'b1; ready = 1'b1;
    step(16);
    en = 1'b0;
    step();
    chk("t1_drained_valid", {7'b0, valid}, 8'h00);

    // T2: back-pressure holds word 0011, then release steps to 0010
    q_w.push_back(5'b0011_0);
    load = 1'b1; ld_val = 4'd2; ready = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_g_out", {4'b0, g_out}, 8'h03);
      chk("t2_hold_valid", {7'b0, valid}, 8'h01);
    end
    q_w.push_back(5'b0010_0);
    ready = 1'b1;
    step();
    en = 1'b0;
    step();

    // T3: load 1, count down through 0 to 15
    q_w.push_back(5'b0001_0);
    q_w.push_back(5'b0000_1);
    q_w.push_back(5'b1000_0);
    load = 1'b1; ld_val = 4'd1; up = 1'b0; ready = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    step(2);
    en = 1'b0;
    step();

    // T4: load over a pending word discards it (15+1 wraps to 0000, never consumed)
    en = 1'b1; up = 1'b1; ready = 1'b0;
    step();
    chk("t4_pending_g_out", {4'b0, g_out}, 8'h00);
    q_w.push_back(5'b1111_0);
    en = 1'b0; load = 1'b1; ld_val = 4'd10;
    step();
    chk("t4_load_g_out", {4'b0, g_out}, 8'h0F);
    chk("t4_load_valid", {7'b0, valid}, 8'h01);
    load = 1'b0; ready = 1'b1;
    step();

    // T6: reset flushes a pending word
    load = 1'b1; ld_val = 4'd4; ready = 1'b0;
    step();
    load = 1'b0;
    chk("t6_pending_g_out", {4'b0, g_out}, 8'h06);
    rst = 1'b1;
    step();
    chk("t6_reset_g_out", {4'b0, g_out}, 8'h00);
    chk("t6_reset_valid", {7'b0, valid}, 8'h00);
    chk("t6_reset_tc",    {7'b0, tc},    8'h00);
    rst = 1'b0;

    // T5: saturating instance stops at 15 going up
    q_s.push_back(5'b1000_1);
    rst_s = 1'b0; load_s = 1'b1; ld_s = 4'd15; up_s = 1'b1; ready_s = 1'b1;
    step();
    load_s = 1'b0; en_s = 1'b1;
    step(4);
    chk("t5_sat_up_valid", {7'b0, valid_s}, 8'h00);
    chk("t5_sat_up_g_out", {4'b0, g_out_s}, 8'h08);

    // Saturating instance stops at 0 going down
    q_s.push_back(5'b0000_1);
    en_s = 1'b0; load_s = 1'b1; ld_s = 4'd0; up_s = 1'b0;
    step();
    load_s = 1'b0; en_s = 1'b1;
    step(3);
    chk("sat_down_valid", {7'b0, valid_s}, 8'h00);
    chk("sat_down_g_out", {4'b0, g_out_s}, 8'h00);
    en_s = 1'b0;
    step();

    chk("wrap_queue_empty", 8'(q_w.size()), 8'h00);
    chk("sat_queue_empty",  8'(q_s.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
